// File: rtl/seg_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scanner.
// Segment vectors are {a,b,c,d,e,f,g} with bit 6 = a, 1 = lit (before polarity).
package seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'b0000000;
    localparam logic [6:0] SEG_0   = 7'b1111110;
    localparam logic [6:0] SEG_1   = 7'b0110000;
    localparam logic [6:0] SEG_2   = 7'b1101101;
    localparam logic [6:0] SEG_3   = 7'b1111001;
    localparam logic [6:0] SEG_4   = 7'b0110011;
    localparam logic [6:0] SEG_5   = 7'b1011011;
    localparam logic [6:0] SEG_6   = 7'b1011111;
    localparam logic [6:0] SEG_7   = 7'b1110000;
    localparam logic [6:0] SEG_8   = 7'b1111111;
    localparam logic [6:0] SEG_9   = 7'b1111011;

    // Per-digit step phase: dead time first, then the PWM-lit window.
    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } step_state_t;

    // BCD digit to segment pattern; codes 10..15 show nothing.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
        case (v)
            4'd0:    bcd_to_seg = SEG_0;
            4'd1:    bcd_to_seg = SEG_1;
            4'd2:    bcd_to_seg = SEG_2;
            4'd3:    bcd_to_seg = SEG_3;
            4'd4:    bcd_to_seg = SEG_4;
            4'd5:    bcd_to_seg = SEG_5;
            4'd6:    bcd_to_seg = SEG_6;
            4'd7:    bcd_to_seg = SEG_7;
            4'd8:    bcd_to_seg = SEG_8;
            4'd9:    bcd_to_seg = SEG_9;
            default: bcd_to_seg = SEG_OFF;
        endcase
    endfunction

    // Clock cycles spent on each digit for a given frame refresh rate.
    function automatic int step_cycles(input int clk_hz, input int refresh_hz, input int digits);
        return clk_hz / (refresh_hz * digits);
    endfunction

endpackage

// File: rtl/seg_decode_blank.sv
// Combinational segment decode for the digit currently being scanned,
// including leading-zero suppression counted down from the leftmost digit.
module seg_decode_blank
    import seg_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int IDX_W  = 2
) (
    input  logic [4*DIGITS-1:0] disp_bcd,
    input  logic [DIGITS-1:0]   disp_dp,
    input  logic [IDX_W-1:0]    idx,
    input  logic                lz_blank,
    output logic [6:0]          seg_raw,
    output logic                dp_raw
);

    logic       lead;
    logic       blank;
    logic [3:0] digit;

    // Walk from the top digit down; 'lead' stays set while every digit so far is a bare zero.
    always_comb begin
        lead  = lz_blank;
        blank = 1'b0;
        digit = disp_bcd[{idx, 2'b00} +: 4];
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if ((disp_bcd[4*i +: 4] != 4'd0) || disp_dp[i]) begin
                lead = 1'b0;
            end
            if (IDX_W'(i) == idx) begin
                blank = lead;
            end
        end
        seg_raw = blank ? SEG_OFF : bcd_to_seg(digit);
        dp_raw  = disp_dp[idx];
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed N-digit common-cathode 7-segment driver with a double-buffered
// load port, dead time between digits, 16-level PWM and selectable polarity.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int CLK_HZ         = 50_000_000,
    parameter int DIGITS         = 4,
    parameter int REFRESH_HZ     = 60,
    parameter int BLANK_CYC      = 500,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int EN_ACTIVE_LOW  = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [4*DIGITS-1:0] load_bcd,
    input  logic [DIGITS-1:0]   load_dp,
    input  logic                lz_blank,
    input  logic [3:0]          brightness,
    output logic [6:0]          seg,
    output logic                dp,
    output logic [DIGITS-1:0]   dig_en,
    output logic                frame_tick
);

    localparam int STEP  = step_cycles(CLK_HZ, REFRESH_HZ, DIGITS);
    localparam int CNT_W = $clog2(STEP);
    localparam int IDX_W = $clog2(DIGITS);

    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(STEP - 1);
    localparam logic [CNT_W-1:0]  CNT_PRE    = CNT_W'(STEP - 2);
    localparam logic [CNT_W-1:0]  CNT_BLANKL = CNT_W'(BLANK_CYC - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DIGITS - 1);
    localparam logic [6:0]        SEG_MASK   = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic              DP_MASK    = (SEG_ACTIVE_LOW != 0);
    localparam logic [DIGITS-1:0] EN_MASK    = (EN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic [3:0]          pwm;
    step_state_t         state;
    logic [4*DIGITS-1:0] disp_bcd;
    logic [DIGITS-1:0]   disp_dp;
    logic [4*DIGITS-1:0] pend_bcd;
    logic [DIGITS-1:0]   pend_dp;
    logic [6:0]          seg_raw;
    logic                dp_raw;
    logic [DIGITS-1:0]   onehot;
    logic                step_end;
    logic                last_digit;
    logic                boundary;
    logic                lit;

    assign step_end   = (cnt == CNT_LAST);
    assign last_digit = (idx == IDX_LAST);
    assign boundary   = step_end && last_digit;
    assign onehot     = DIGITS'(1) << idx;
    assign lit        = (brightness == 4'hF) || (pwm < brightness);

    seg_decode_blank #(
        .DIGITS (DIGITS),
        .IDX_W  (IDX_W)
    ) u_decode (
        .disp_bcd (disp_bcd),
        .disp_dp  (disp_dp),
        .idx      (idx),
        .lz_blank (lz_blank),
        .seg_raw  (seg_raw),
        .dp_raw   (dp_raw)
    );

    // Step counter, scan index and the BLANK/ON phase with its PWM counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            idx   <= '0;
            pwm   <= '0;
            state <= ST_BLANK;
        end else if (step_end) begin
            cnt   <= '0;
            idx   <= last_digit ? '0 : idx + 1'b1;
            state <= ST_BLANK;
        end else begin
            cnt <= cnt + 1'b1;
            case (state)
                ST_BLANK: begin
                    if (cnt == CNT_BLANKL) begin
                        state <= ST_ON;
                        pwm   <= '0;
                    end
                end
                ST_ON:   pwm <= pwm + 1'b1;
                default: state <= ST_BLANK;
            endcase
        end
    end

    // Load handshake into the pending buffer; swap into the display at the frame boundary.
    // frame_tick is registered one cycle early so it is high on the boundary cycle itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            load_ready <= 1'b1;
            frame_tick <= 1'b0;
            pend_bcd   <= '0;
            pend_dp    <= '0;
            disp_bcd   <= '0;
            disp_dp    <= '0;
        end else begin
            frame_tick <= last_digit && (cnt == CNT_PRE);
            if (boundary && !load_ready) begin
                disp_bcd   <= pend_bcd;
                disp_dp    <= pend_dp;
                load_ready <= 1'b1;
            end else if (load_valid && load_ready) begin
                pend_bcd   <= load_bcd;
                pend_dp    <= load_dp;
                load_ready <= 1'b0;
            end
        end
    end

    // Registered, polarity-adjusted display outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg    <= SEG_OFF ^ SEG_MASK;
            dp     <= DP_MASK;
            dig_en <= EN_MASK;
        end else begin
            seg    <= ((state == ST_ON) ? seg_raw : SEG_OFF) ^ SEG_MASK;
            dp     <= ((state == ST_ON) && dp_raw) ^ DP_MASK;
            dig_en <= (((state == ST_ON) && lit) ? onehot : '0) ^ EN_MASK;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: a cycle-level reference model pushes the
// expected outputs of every cycle, a monitor pops and compares both a
// positive-polarity and an inverted-polarity instance.
module tb_seg_scan_driver;

    localparam int DIGITS = 4;
    localparam int STEP   = 20;
    localparam int BLANK  = 4;
    localparam int FRAME  = STEP * DIGITS;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] en;
        logic       ft;
        logic       rdy;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_valid = 1'b0;
    logic [15:0] load_bcd = '0;
    logic [3:0]  load_dp = '0;
    logic        lz_blank = 1'b0;
    logic [3:0]  brightness = 4'hF;

    logic        load_ready, dp, frame_tick;
    logic [6:0]  seg;
    logic [3:0]  dig_en;
    logic        load_ready_n, dp_n, frame_tick_n;
    logic [6:0]  seg_n;
    logic [3:0]  dig_en_n;

    int checks = 0;
    int errors = 0;

    exp_t exp_q[$];

    // reference model state
    int          m_k;
    logic [15:0] m_disp_bcd, m_pend_bcd;
    logic [3:0]  m_disp_dp, m_pend_dp;
    bit          m_full;

    seg_scan_driver #(
        .CLK_HZ(4800), .DIGITS(DIGITS), .REFRESH_HZ(60), .BLANK_CYC(BLANK),
        .SEG_ACTIVE_LOW(0), .EN_ACTIVE_LOW(0)
    ) dut (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
        .load_bcd(load_bcd), .load_dp(load_dp), .lz_blank(lz_blank), .brightness(brightness),
        .seg(seg), .dp(dp), .dig_en(dig_en), .frame_tick(frame_tick)
    );

    seg_scan_driver #(
        .CLK_HZ(4800), .DIGITS(DIGITS), .REFRESH_HZ(60), .BLANK_CYC(BLANK),
        .SEG_ACTIVE_LOW(1), .EN_ACTIVE_LOW(1)
    ) dut_inv (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready_n),
        .load_bcd(load_bcd), .load_dp(load_dp), .lz_blank(lz_blank), .brightness(brightness),
        .seg(seg_n), .dp(dp_n), .dig_en(dig_en_n), .frame_tick(frame_tick_n)
    );

    always #5 clk = ~clk;

    // Segment pattern from the list of lit segment letters.
    function automatic logic [6:0] seg_of(input int v);
        string      lit;
        logic [6:0] r = '0;
        case (v)
            0: lit = "abcdef";
            1: lit = "bc";
            2: lit = "abdeg";
            3: lit = "abcdg";
            4: lit = "bcfg";
            5: lit = "acdfg";
            6: lit = "acdefg";
            7: lit = "abc";
            8: lit = "abcdefg";
            9: lit = "abcdfg";
            default: lit = "";
        endcase
        for (int i = 0; i < lit.len(); i++) r[6 - (int'(lit[i]) - 97)] = 1'b1;
        return r;
    endfunction

    // Last cycle of the last digit's step within a frame.
    function automatic bit is_boundary(input int k);
        return (k % FRAME) == FRAME - 1;
    endfunction

    // A digit is suppressed when it and every digit to its left are bare zeros.
    function automatic bit blanked(input int id, input logic [15:0] b, input logic [3:0] d, input logic lz);
        if (!lz || id == 0) return 1'b0;
        for (int j = DIGITS - 1; j >= id; j--)
            if (b[4*j +: 4] != 4'd0 || d[j]) return 1'b0;
        return 1'b1;
    endfunction

    // Advance the model by one clock edge and queue what the outputs must show afterwards.
    task automatic model_step();
        exp_t e;
        int   pos, id;
        if (reset) begin
            m_k = 0; m_full = 0;
            m_disp_bcd = '0; m_disp_dp = '0;
            e = '{seg: 7'd0, dp: 1'b0, en: 4'd0, ft: 1'b0, rdy: 1'b1};
        end else begin
            pos  = m_k % STEP;
            id   = (m_k / STEP) % DIGITS;
            e.ft = is_boundary(m_k + 1);
            if (pos < BLANK) begin
                e.seg = '0; e.dp = 1'b0; e.en = '0;
            end else begin
                e.seg = blanked(id, m_disp_bcd, m_disp_dp, lz_blank) ? 7'd0 : seg_of(int'(m_disp_bcd[4*id +: 4]));
                e.dp  = m_disp_dp[id];
                e.en  = (brightness == 4'd15 || ((pos - BLANK) % 16) < int'(brightness)) ? 4'(1 << id) : 4'd0;
            end
            if (is_boundary(m_k) && m_full) begin
                m_disp_bcd = m_pend_bcd; m_disp_dp = m_pend_dp; m_full = 0;
            end else if (load_valid && !m_full) begin
                m_pend_bcd = load_bcd; m_pend_dp = load_dp; m_full = 1;
            end
            e.rdy = !m_full;
            m_k++;
        end
        exp_q.push_back(e);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Monitor: one expected record per cycle, compared against both instances.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({seg, dp, dig_en, frame_tick, load_ready} !== e) begin
                errors++;
                $display("FAIL out_pos t=%0t got seg=%b dp=%b en=%b ft=%b rdy=%b exp seg=%b dp=%b en=%b ft=%b rdy=%b",
                         $time, seg, dp, dig_en, frame_tick, load_ready, e.seg, e.dp, e.en, e.ft, e.rdy);
            end
            checks++;
            if ({seg_n, dp_n, dig_en_n, frame_tick_n, load_ready_n} !== {~e.seg, ~e.dp, ~e.en, e.ft, e.rdy}) begin
                errors++;
                $display("FAIL out_inv t=%0t got seg=%b dp=%b en=%b ft=%b rdy=%b exp seg=%b dp=%b en=%b ft=%b rdy=%b",
                         $time, seg_n, dp_n, dig_en_n, frame_tick_n, load_ready_n, ~e.seg, ~e.dp, ~e.en, e.ft, e.rdy);
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves the caller 1 time unit into internal cycle 0.
    task automatic do_reset(input int n);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Offer a word and hold it until accepted (bounded wait).
    task automatic offer(input logic [15:0] b, input logic [3:0] d);
        int waited = 0;
        load_bcd = b; load_dp = d; load_valid = 1'b1;
        @(negedge clk);
        while (!load_ready && waited < 4 * FRAME) begin
            @(negedge clk);
            waited++;
        end
        if (!load_ready) begin
            checks++; errors++;
            $display("FAIL load_accept timeout got ready=%b required 1", load_ready);
        end
        @(posedge clk); #1;
        load_valid = 1'b0;
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 3) == 0) w[4*i +: 4] = 4'($urandom_range(0, 15));
            else if ($urandom_range(0, 1) == 0) w[4*i +: 4] = 4'd0;
            else w[4*i +: 4] = 4'($urandom_range(0, 9));
        end
        return w;
    endfunction

    initial begin
        // power-on display, no load
        do_reset(3);
        run(2 * FRAME);
        // mid-frame load with a decimal point
        run(30);
        offer(16'h1234, 4'b0010);
        run(2 * FRAME + 20);
        // leading-zero blanking
        lz_blank = 1'b1;
        offer(16'h0070, 4'b0000);
        run(2 * FRAME + 20);
        offer(16'h0070, 4'b0100);
        run(2 * FRAME + 20);
        // a second offer while the pending buffer is full
        lz_blank = 1'b0;
        offer(16'h5678, 4'b0001);
        load_bcd = 16'h9999; load_dp = 4'b1111; load_valid = 1'b1;
        run(5);
        load_valid = 1'b0;
        run(2 * FRAME);
        // load offered exactly on the boundary cycle
        do_reset(2);
        run(FRAME - 1);
        load_bcd = 16'h2468; load_dp = 4'b1000; load_valid = 1'b1;
        run(1);
        load_valid = 1'b0;
        run(3 * FRAME);
        // brightness sweep
        brightness = 4'd0;
        run(2 * FRAME);
        brightness = 4'd4;
        run(2 * FRAME);
        brightness = 4'd15;
        // reset mid-step with a full pending buffer
        offer(16'h4321, 4'b1111);
        run(7);
        do_reset(1);
        run(2 * FRAME);
        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            lz_blank = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0:       brightness = 4'd0;
                1, 2:    brightness = 4'd15;
                default: brightness = 4'($urandom_range(1, 14));
            endcase
            offer(rand_word(), ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0);
            run($urandom_range(0, 60));
            brightness = 4'($urandom_range(0, 15));
            run($urandom_range(0, 60));
            if ($urandom_range(0, 9) == 0) do_reset($urandom_range(1, 3));
        end
        run(2 * FRAME);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
